// File: rtl/traffic_input_cond.sv
// traffic_input_cond: input-conditioning stage in front of the fsm2 traffic
// controller. Four channels (street sensors A/B, parade button P, release
// button R) are each synchronised with two flops, debounced over DB_CYCLES
// samples, and then presented as levels (ta/tb) or one-cycle pulses (p/r).
// Optional feature: define SENSOR_STRETCH_EN to keep ta/tb high for
// HOLD_CYCLES cycles after the debounced sensor release.
module traffic_input_cond #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_p,
  input  logic raw_r,
  output logic ta,
  output logic tb,
  output logic p,
  output logic r
);

  // Channel slots inside the packed per-channel vectors.
  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_P = 2;
  localparam int CH_R = 3;

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("traffic_input_cond: DB_CYCLES and HOLD_CYCLES must both be >= 1");
  end

  logic [3:0]    raw_vec;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    q;
  logic [3:0]    q_next;
  logic [CW-1:0] cnt [4];
  logic [CW-1:0] cnt_next [4];
  logic [CH_R:CH_P] q_d;
  logic          p_raw;
  logic          r_raw;

  assign raw_vec = {raw_r, raw_p, raw_b, raw_a};

  // Two-flop synchroniser for every asynchronous raw input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
    end
  end

  // Debounce decision: a differing sample either extends the run or, on the
  // last required sample, is accepted; any agreeing sample restarts the run.
  always_comb begin
    q_next = q;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          q_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced levels and their run counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      q <= q_next;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // One-cycle history of the button levels for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_d <= '0;
    end else begin
      q_d <= q[CH_R:CH_P];
    end
  end

  // Release beats parade when both are accepted together, so the controller
  // never enters parade mode on a simultaneous press.
  assign p_raw = q[CH_P] & ~q_d[CH_P];
  assign r_raw = q[CH_R] & ~q_d[CH_R];
  assign p     = p_raw & ~r_raw;
  assign r     = r_raw;

`ifdef SENSOR_STRETCH_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold [2];

  // Sensor hold timers: loaded on a debounced release, cleared on a new
  // arrival, otherwise counting down to zero to bridge gaps between cars.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold[CH_A] <= '0;
      hold[CH_B] <= '0;
    end else begin
      for (int i = CH_A; i <= CH_B; i++) begin
        if (!q[i] && q_next[i]) begin
          hold[i] <= '0;
        end else if (q[i] && !q_next[i]) begin
          hold[i] <= HOLD_LOAD;
        end else if (hold[i] != '0) begin
          hold[i] <= hold[i] - 1'b1;
        end
      end
    end
  end

  assign ta = q[CH_A] | (hold[CH_A] != '0);
  assign tb = q[CH_B] | (hold[CH_B] != '0);
`else
  assign ta = q[CH_A];
  assign tb = q[CH_B];
`endif

endmodule
